// File: rtl/motor_cmd_sequencer.sv
// ============================================================================
// Module  : motor_cmd_sequencer
// Brief   : Queues timed motion commands and issues frame-aligned drive
//           instructions, inserting stop frames on direction reversal.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module motor_cmd_sequencer #(
  parameter int FRAME_LEN  = 3072,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_dir,
  input  logic [7:0] cmd_frames,
  output logic       cmd_ready,
  output logic [1:0] instr,
  output logic       frame_tick,
  output logic       busy
);

  localparam int CW = $clog2(FRAME_LEN);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = $clog2(GAP_FRAMES + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(FRAME_LEN - 1);
  localparam logic [AW:0]   FIFO_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_FRAMES);
  localparam logic [GW-1:0] GAP_ONE   = GW'(1);
  localparam logic [1:0]    DIR_FWD   = 2'b01;
  localparam logic [1:0]    DIR_BACK  = 2'b10;
  localparam logic [1:0]    DIR_STOP  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  logic [CW-1:0] cnt_q;

  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push, pop, fifo_empty, reversal;
  logic [1:0]    wr_dir, head_dir;
  logic [7:0]    head_frames;

  state_t        state_q, state_d;
  logic [1:0]    instr_q, instr_d;
  logic [7:0]    remaining_q, remaining_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [9:0]    pending_q, pending_d;

  assign frame_tick = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           cnt_q <= '0;
    else if (frame_tick) cnt_q <= '0;
    else                 cnt_q <= cnt_q + 1'b1;
  end

  // Ready depends only on occupancy, so a full FIFO refuses a push even on a pop cycle.
  assign cmd_ready   = (count_q != FIFO_FULL);
  assign fifo_empty  = (count_q == '0);
  assign wr_dir      = (cmd_dir == 2'b00) ? DIR_STOP : cmd_dir;
  assign push        = cmd_valid & cmd_ready & (cmd_frames != 8'd0);
  assign head_dir    = mem_q[rd_ptr_q][9:8];
  assign head_frames = mem_q[rd_ptr_q][7:0];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {wr_dir, cmd_frames};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign reversal = ((head_dir == DIR_FWD)  && (instr_q == DIR_BACK)) ||
                    ((head_dir == DIR_BACK) && (instr_q == DIR_FWD));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      instr_q     <= DIR_STOP;
      remaining_q <= '0;
      gap_q       <= '0;
      pending_q   <= '0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      remaining_q <= remaining_d;
      gap_q       <= gap_d;
      pending_q   <= pending_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    remaining_d = remaining_q;
    gap_d       = gap_q;
    pending_d   = pending_q;
    pop         = 1'b0;
    if (frame_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            pop         = 1'b1;
            instr_d     = head_dir;
            remaining_d = head_frames;
            state_d     = ST_RUN;
          end
        end
        ST_RUN: begin
          if (remaining_q > 8'd1) begin
            remaining_d = remaining_q - 8'd1;
          end else if (!fifo_empty) begin
            pop = 1'b1;
            if (reversal) begin
              instr_d   = DIR_STOP;
              gap_d     = GAP_LOAD;
              pending_d = {head_dir, head_frames};
              state_d   = ST_GAP;
            end else begin
              instr_d     = head_dir;
              remaining_d = head_frames;
            end
          end else begin
            instr_d = DIR_STOP;
            state_d = ST_IDLE;
          end
        end
        ST_GAP: begin
          if (gap_q > GAP_ONE) begin
            gap_d = gap_q - 1'b1;
          end else begin
            instr_d     = pending_q[9:8];
            remaining_d = pending_q[7:0];
            state_d     = ST_RUN;
          end
        end
        default: begin
          instr_d = DIR_STOP;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign instr = instr_q;
  assign busy  = (state_q != ST_IDLE) | !fifo_empty;

endmodule

`default_nettype wire

// File: tb/tb_motor_cmd_sequencer.sv
// ============================================================================
// Module  : tb_motor_cmd_sequencer
// Brief   : Directed self-checking bench for motor_cmd_sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_motor_cmd_sequencer;

  logic       clk = 1'b0;
  logic       reset, cmd_valid, cmd_ready, frame_tick, busy;
  logic [1:0] cmd_dir, instr;
  logic [7:0] cmd_frames;
  logic       reset2, cmd_valid2, cmd_ready2, frame_tick2, busy2;
  logic [1:0] cmd_dir2, instr2;
  logic [7:0] cmd_frames2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  motor_cmd_sequencer #(.FRAME_LEN(16), .FIFO_DEPTH(4), .GAP_FRAMES(2)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_dir    (cmd_dir),
    .cmd_frames (cmd_frames),
    .cmd_ready  (cmd_ready),
    .instr      (instr),
    .frame_tick (frame_tick),
    .busy       (busy)
  );

  motor_cmd_sequencer u_dut_long (
    .clk        (clk),
    .reset      (reset2),
    .cmd_valid  (cmd_valid2),
    .cmd_dir    (cmd_dir2),
    .cmd_frames (cmd_frames2),
    .cmd_ready  (cmd_ready2),
    .instr      (instr2),
    .frame_tick (frame_tick2),
    .busy       (busy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called on a negedge; returns on the negedge after the accepting clock edge.
  task automatic push(input logic [1:0] d, input logic [7:0] f);
    cmd_valid  = 1'b1;
    cmd_dir    = d;
    cmd_frames = f;
    for (int k = 0; k < 200 && !cmd_ready; k++) @(negedge clk);
    if (!cmd_ready) chk("push_timeout", 0, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Returns on the first negedge of the next frame with its instruction.
  task automatic next_frame(output logic [1:0] v);
    for (int k = 0; k < 64 && !frame_tick; k++) @(negedge clk);
    if (!frame_tick) chk("tick_timeout", 0, 1);
    @(negedge clk);
    v = instr;
  endtask

  task automatic frame_chk(input string tag, input logic [1:0] exp);
    logic [1:0] v;
    next_frame(v);
    chk(tag, v, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] v;
    int ticks, first, bad, n, np, n10, tick_instr;

    reset = 1'b1; cmd_valid = 1'b0; cmd_dir = 2'b00; cmd_frames = 8'd0;
    reset2 = 1'b1; cmd_valid2 = 1'b0; cmd_dir2 = 2'b00; cmd_frames2 = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_instr", instr, 2'b11);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_tick", frame_tick, 0);
    reset = 1'b0;

    // Idle for 100 cycles: ticks at cycles 15, 31, ..., 95
    ticks = 0; first = -1; bad = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (frame_tick) begin
        ticks++;
        if (first < 0) first = k;
      end
      if (instr != 2'b11 || busy || !cmd_ready) bad++;
    end
    chk("idle_ticks", ticks, 6);
    chk("idle_first_tick", first, 15);
    chk("idle_outputs", bad, 0);

    // Single command, pushed mid-frame
    next_frame(v);
    repeat (5) @(negedge clk);
    push(2'b01, 8'd3);
    frame_chk("single_start", 2'b01);
    n = 0;
    while (instr == 2'b01 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("single_cycles", n, 48);
    chk("single_end_instr", instr, 2'b11);
    chk("single_end_busy", busy, 0);

    // Same direction back to back: no stop frame
    push(2'b01, 8'd2);
    push(2'b01, 8'd1);
    frame_chk("b2b_f0", 2'b01);
    frame_chk("b2b_f1", 2'b01);
    frame_chk("b2b_f2", 2'b01);
    frame_chk("b2b_f3", 2'b11);

    // Reversal: two gap frames
    push(2'b01, 8'd1);
    push(2'b10, 8'd1);
    frame_chk("rev_f0", 2'b01);
    frame_chk("rev_f1", 2'b11);
    frame_chk("rev_f2", 2'b11);
    frame_chk("rev_f3", 2'b10);
    frame_chk("rev_f4", 2'b11);

    // Stop command separates directions without a gap
    push(2'b01, 8'd1);
    push(2'b11, 8'd1);
    push(2'b10, 8'd1);
    frame_chk("sep_f0", 2'b01);
    frame_chk("sep_f1", 2'b11);
    frame_chk("sep_f2", 2'b10);
    frame_chk("sep_f3", 2'b11);

    // Zero-length command is swallowed
    push(2'b01, 8'd0);
    chk("zero_busy", busy, 0);
    frame_chk("zero_f0", 2'b11);
    chk("zero_busy_after", busy, 0);

    // Illegal direction runs as two stop frames
    push(2'b00, 8'd2);
    chk("ill_busy_q", busy, 1);
    frame_chk("ill_f0", 2'b11);
    chk("ill_busy_f0", busy, 1);
    frame_chk("ill_f1", 2'b11);
    chk("ill_busy_f1", busy, 1);
    frame_chk("ill_f2", 2'b11);
    chk("ill_busy_f2", busy, 0);

    // FIFO full with cmd_valid held high
    next_frame(v);
    cmd_valid = 1'b1; cmd_dir = 2'b10; cmd_frames = 8'd4;
    np = 0;
    for (int k = 0; k < 40 && np < 4; k++) begin
      if (cmd_ready) np++;
      @(negedge clk);
    end
    chk("full_pushes", np, 4);
    chk("full_ready", cmd_ready, 0);
    bad = 0;
    for (int k = 0; k < 64 && !frame_tick; k++) begin
      if (cmd_ready) bad++;
      @(negedge clk);
    end
    chk("full_hold", bad, 0);
    chk("full_tick_seen", frame_tick, 1);
    @(negedge clk);
    chk("full_ready_after_pop", cmd_ready, 1);
    n10 = 0;
    for (int k = 0; k < 800; k++) begin
      if (instr == 2'b10) n10++;
      @(negedge clk);
      if (k == 0) cmd_valid = 1'b0;
      if (!busy) break;
    end
    chk("full_back_cycles", n10, 320);
    chk("full_end_instr", instr, 2'b11);

    // Asynchronous reset mid-run with three commands queued
    next_frame(v);
    push(2'b01, 8'd5);
    frame_chk("ar_run", 2'b01);
    push(2'b01, 8'd2);
    push(2'b01, 8'd2);
    push(2'b01, 8'd2);
    repeat (4) @(negedge clk);
    chk("ar_busy_before", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("ar_instr", instr, 2'b11);
    chk("ar_ready", cmd_ready, 1);
    chk("ar_busy", busy, 0);
    chk("ar_tick", frame_tick, 0);
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    for (int k = 0; k < 64 && !frame_tick; k++) begin
      n++;
      @(negedge clk);
    end
    chk("ar_cnt_restart", n, 15);
    @(negedge clk);
    chk("ar_instr_after", instr, 2'b11);
    chk("ar_busy_after", busy, 0);

    // Full-length frame: instruction changes only at count 0
    reset2 = 1'b0;
    cmd_valid2 = 1'b1; cmd_dir2 = 2'b10; cmd_frames2 = 8'd1;
    @(negedge clk);
    cmd_valid2 = 1'b0;
    n = 1; tick_instr = -1;
    while (instr2 == 2'b11 && n < 4000) begin
      if (frame_tick2) tick_instr = instr2;
      @(negedge clk);
      n++;
    end
    chk("long_change_cycle", n, 3072);
    chk("long_instr_at_tick", tick_instr, 3);
    chk("long_instr", instr2, 2'b10);
    repeat (100) @(negedge clk);
    #2 reset2 = 1'b1;
    #1;
    chk("long_ar_instr", instr2, 2'b11);
    chk("long_ar_busy", busy2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/motor_cmd_sequencer.md
Name: motor_cmd_sequencer

Overview:
- Upstream command stage for the servo PWM driver.
- Accepts timed motion commands (direction plus duration in PWM frames) over a valid/ready handshake and buffers them in a small FIFO.
- Presents the 2-bit drive instruction that the PWM driver consumes.
- Changes the instruction only at PWM frame boundaries and inserts mandatory stop frames on direction reversal.

Parameters:
- FRAME_LEN, 3072, clock cycles per PWM frame; must match the PWM driver period.
- FIFO_DEPTH, 4, command FIFO entries; power of two, at least 2.
- GAP_FRAMES, 2, stop frames inserted between opposite-direction commands; at least 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present on cmd_dir/cmd_frames.
- cmd_dir  in  2  01 forward, 10 back, 11 stop, 00 illegal (treated as stop).
- cmd_frames  in  8  duration in frames; 0 means discard.
- cmd_ready  out  1  FIFO can accept a command this cycle.
- instr  out  2  drive instruction to the PWM driver (01 fwd, 10 back, 11 stop).
- frame_tick  out  1  high for the one cycle where the frame counter equals FRAME_LEN-1.
- busy  out  1  state is not IDLE, or the FIFO is non-empty.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-command):
  - instr=11, cmd_ready=1, busy=0, frame_tick=0.
  - Frame counter=0, FIFO emptied, state=IDLE, prev_dir=11.
- Frame counter: counts 0..FRAME_LEN-1 then wraps to 0 and free-runs. frame_tick is combinational from the count.
- Handshake:
  - A push occurs when cmd_valid & cmd_ready at a clk edge.
  - cmd_ready = !full. It is computed from the FIFO count only, so when the FIFO is full a same-cycle pop does not allow a push.
  - Commands with cmd_frames=0 are accepted (ready honoured) but not written into the FIFO.
  - cmd_dir=00 is normalised to 11 on write.
- Timing rule: every state or instr change happens on the clk edge at which frame_tick=1. The new instr is therefore valid from frame-counter value 0, aligned to the driver period.
- Pops occur only on a frame_tick edge.
- Registers:
  - remaining (8b): frames left in the current command.
  - gap_cnt: stop frames left in the current gap.
  - pending: the popped command waiting behind a gap.
- Reversal: the new dir and prev_dir are 01/10 opposites. prev_dir is the instr value output during the frame just ending.
- State machine:
  - IDLE: instr=11.
    - On tick with FIFO non-empty: pop; instr<=dir; remaining<=frames; go to RUN. No gap is needed because the previous frame was a stop.
  - RUN:
    - On tick with remaining>1: remaining<=remaining-1.
    - On tick with remaining==1 and FIFO non-empty: pop.
      - If reversal: instr<=11; gap_cnt<=GAP_FRAMES; pending<=popped; go to GAP.
      - Otherwise: instr<=dir; remaining<=frames; stay in RUN.
    - On tick with remaining==1 and FIFO empty: instr<=11; go to IDLE.
  - GAP: instr=11.
    - On tick with gap_cnt>1: gap_cnt<=gap_cnt-1.
    - On tick with gap_cnt==1: instr<=pending dir; remaining<=pending frames; go to RUN.
- A stop command (11) counts as a normal timed command. The step after it is never a reversal, because prev_dir=11.
- Each command therefore occupies exactly cmd_frames frames of instr, and each gap occupies exactly GAP_FRAMES frames.
- FIFO: circular buffer with a pointer wrap at FIFO_DEPTH. Push and pop in the same cycle while not full are both performed, and the count is unchanged.
- Widths:
  - Frame counter is $clog2(FRAME_LEN) bits (12 at the default).
  - FIFO count is $clog2(FIFO_DEPTH)+1 bits.

Test Plan (FRAME_LEN=16, FIFO_DEPTH=4, GAP_FRAMES=2 unless noted):
- Reset: release reset and idle 100 cycles -> instr=11, cmd_ready=1, busy=0; frame_tick pulses every 16 cycles.
- Single command: push {01, 3} mid-frame -> instr=01 from the next frame start, for exactly 48 cycles, then 11; busy then falls.
- Back-to-back commands: push {01,2} then {01,1} -> 01 for 3 consecutive frames with no stop frame. Then push {01,1} then {10,1} -> pattern 01 / 11 / 11 / 10 / 11.
- Stop separator and edge inputs: push {01,1}, {11,1}, {10,1} -> 01 / 11 / 10 with no extra gap. Push {01,0} -> accepted, no effect. Push {00,2} -> 2 stop frames.
- FIFO full: push 5 commands {10,4} with cmd_valid held high -> cmd_ready=0 after the 4th push. The 5th is accepted only after the first pop at a frame tick. All 5 execute, 20 frames of 10.
- Async reset mid-run: assert reset mid-frame during RUN with 3 queued commands -> instr=11 in the same cycle without waiting for a clk edge, and the FIFO is empty after release. Repeat with FRAME_LEN=3072 -> instr changes only at count 0.
